// File: rtl/uart_rx_deserializer.sv
// UART receiver for 7-bit frames: start, data[0..6] LSB first, parity, stop.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote around mid-bit.
module uart_rx_deserializer #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       os_tick,
  input  logic       rxd,
  input  logic       data_ack,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int HALF = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_DEC = HALF;
`else
  localparam int START_DEC = HALF - 1;
`endif
  localparam logic [TW-1:0] START_LAST = TW'(START_DEC);
  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_rxsPrev;
  logic [TW-1:0]   r_tick;
  logic [2:0]      r_bitCnt;
  logic [6:0]      r_shift;
  logic            r_parity;
  logic [6:0]      r_dataOut;
  logic            r_dataValid;
  logic            r_parityErr;
  logic            r_frameErr;
  logic            r_overrun;
  logic            r_busy;

  logic            w_rxs;
  logic            w_fall;
  logic            w_bit;
  logic [TW-1:0]   w_tickNext;
  logic            w_parityErr;

  // Presetting the synchronizer to idle-high keeps reset release from looking like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rxsPrev <= 1'b1;
    end else begin
      r_sync1   <= rxd;
      r_sync2   <= r_sync1;
      r_rxsPrev <= r_sync2;
    end
  end

  assign w_rxs  = r_sync2;
  assign w_fall = r_rxsPrev & ~w_rxs;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_samp;

  // The two previous tick samples plus the current one form the SP-1/SP/SP+1 vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp <= 2'b11;
    end else if (os_tick) begin
      r_samp <= {r_samp[0], w_rxs};
    end
  end

  assign w_bit = (r_samp[1] & r_samp[0]) | (r_samp[1] & w_rxs) | (r_samp[0] & w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  assign w_tickNext  = (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
  assign w_parityErr = ((^r_shift) ^ r_parity) != PARITY_ODD;

  // A completing frame is handled after the ack clear so that it wins when both land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (data_ack && r_dataValid) begin
        r_dataValid <= 1'b0;
        r_parityErr <= 1'b0;
        r_frameErr  <= 1'b0;
        r_overrun   <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_tick  <= '0;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (os_tick) begin
            if (r_tick == START_LAST) begin
              if (w_bit) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state  <= DATA;
                r_bitCnt <= '0;
                r_tick   <= '0;
              end
            end else begin
              r_tick <= w_tickNext;
            end
          end
        end

        DATA: begin
          if (os_tick) begin
            r_tick <= w_tickNext;
            if (r_tick == TICK_LAST) begin
              r_shift  <= {w_bit, r_shift[6:1]};
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd6) begin
                r_state <= PARITY;
              end
            end
          end
        end

        PARITY: begin
          if (os_tick) begin
            r_tick <= w_tickNext;
            if (r_tick == TICK_LAST) begin
              r_parity <= w_bit;
              r_state  <= STOP;
            end
          end
        end

        STOP: begin
          if (os_tick) begin
            r_tick <= w_tickNext;
            if (r_tick == TICK_LAST) begin
              r_dataOut   <= r_shift;
              r_dataValid <= 1'b1;
              r_parityErr <= w_parityErr;
              r_frameErr  <= ~w_bit;
              if (r_dataValid && !data_ack) begin
                r_overrun <= 1'b1;
              end
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_dataOut;
  assign data_valid = r_dataValid;
  assign parity_err = r_parityErr;
  assign frame_err  = r_frameErr;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule
